// File: rtl/wb_dbg_master_pkg.sv
// wb_dbg_master_pkg: command/response byte codes and FSM states shared by the debug master
package wb_dbg_master_pkg;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_OK    = 8'h06;
  localparam logic [7:0] RSP_FAIL  = 8'h15;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_t;
  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction
endpackage

// File: rtl/wb_dbg_master.sv
// wb_dbg_master: byte-stream driven Wishbone classic initiator, one single-word cycle per command
module wb_dbg_master
  import wb_dbg_master_pkg::*;
#(
  parameter int timeout   = 1023,
  parameter int cnt_width = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_rty_i,
  output logic        busy
);
  state_t r_state, w_next;
  logic [1:0] r_bcnt;
  logic [2:0] r_idx;
  logic [31:0] r_adr, r_dat, r_rdat;
  logic [7:0] r_tx;
  logic r_we, r_ok, r_cyc;
  logic [cnt_width-1:0] r_tmo;
  logic w_rx_hs, w_tx_hs, w_resp, w_tmo_hit, w_last;
  assign w_rx_hs   = rx_valid & rx_ready;
  assign w_tx_hs   = tx_valid & tx_ready;
  assign w_resp    = wb_ack_i | wb_err_i | wb_rty_i;
  assign w_tmo_hit = (timeout != 0) && (r_tmo == cnt_width'(timeout - 1));
  assign w_last    = r_idx == ((r_ok && !r_we) ? 3'd4 : 3'd0);
  // reset gating keeps rx_ready low while reset is held, like every other output
  assign rx_ready = !reset && (r_state inside {S_IDLE, S_ADDR, S_DATA});
  assign tx_valid = r_state == S_RESP;
  assign busy     = r_state != S_IDLE;
  assign tx_data  = r_tx;
  assign wb_adr_o = r_adr & 32'hFFFF_FFFC;
  assign wb_dat_o = r_dat;
  assign wb_we_o  = r_we;
  assign wb_cyc_o = r_cyc;
  assign wb_stb_o = r_cyc;
  assign wb_sel_o = {4{r_cyc}};
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = (w_rx_hs && is_cmd(rx_data)) ? S_ADDR : S_IDLE;
      S_ADDR: w_next = (w_rx_hs && r_bcnt == 2'd3) ? (r_we ? S_DATA : S_BUS) : S_ADDR;
      S_DATA: w_next = (w_rx_hs && r_bcnt == 2'd3) ? S_BUS : S_DATA;
      S_BUS:  w_next = (w_resp || w_tmo_hit) ? S_RESP : S_BUS;
      S_RESP: w_next = (w_tx_hs && w_last) ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_bcnt <= '0;
      r_idx  <= '0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_rdat <= '0;
      r_tx   <= '0;
      r_we   <= 1'b0;
      r_ok   <= 1'b0;
      r_cyc  <= 1'b0;
      r_tmo  <= '0;
    end else begin
      if (w_rx_hs) r_bcnt <= (r_state == S_IDLE) ? 2'd0 : r_bcnt + 2'd1;
      if (r_state == S_IDLE && w_next == S_ADDR) r_we <= rx_data == CMD_WRITE;
      if (r_state == S_ADDR && w_rx_hs) r_adr <= {r_adr[23:0], rx_data};
      if (r_state == S_DATA && w_rx_hs) r_dat <= {r_dat[23:0], rx_data};
      r_cyc <= w_next == S_BUS;
      // saturating so a timeout of 0 can wait indefinitely without wrapping
      r_tmo <= (r_state != S_BUS) ? '0 : ((&r_tmo) ? r_tmo : r_tmo + 1'b1);
      if (r_state == S_BUS && w_next == S_RESP) begin
        r_ok   <= wb_ack_i;
        r_rdat <= wb_dat_i;
        r_tx   <= wb_ack_i ? RSP_OK : RSP_FAIL;
        r_idx  <= '0;
      end else if (w_tx_hs) begin
        r_tx   <= r_rdat[31:24];
        r_rdat <= {r_rdat[23:0], 8'h00};
        r_idx  <= r_idx + 3'd1;
      end
    end
endmodule

// File: tb/tb_wb_dbg_master.sv
// tb_wb_dbg_master: directed and randomized transactions against a transaction-level model
module tb_wb_dbg_master;
  localparam int TMO = 16;
  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_ACKERR = 3, K_NONE = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] rx_data = '0, tx_data;
  logic rx_valid = 1'b0, rx_ready, tx_valid, tx_ready = 1'b1;
  logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [3:0] wb_sel_o;
  logic wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i, wb_err_i, wb_rty_i, busy;
  int vectors = 0, errors = 0;
  int s_kind = K_NONE, s_delay = 0, bus_cnt = 0, ncyc = 0;
  logic [31:0] rd_word = '0;
  logic [7:0] txq[$];
  int cyc_cycles, first_cyc, last_cyc, first_txv, hs_cyc;
  bit cyc_seen, txv_seen, unstable;
  logic [31:0] cap_adr, cap_dat;
  logic cap_we;
  logic [3:0] cap_sel;

  wb_dbg_master #(.timeout(TMO), .cnt_width(5)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .busy(busy)
  );

  always #5 clk = ~clk;

  // slave responds in bus cycle s_delay (0 = zero-wait) with the configured kind
  assign wb_dat_i = rd_word;
  assign wb_ack_i = wb_cyc_o && bus_cnt == s_delay && (s_kind == K_ACK || s_kind == K_ACKERR);
  assign wb_err_i = wb_cyc_o && bus_cnt == s_delay && (s_kind == K_ERR || s_kind == K_ACKERR);
  assign wb_rty_i = wb_cyc_o && bus_cnt == s_delay && s_kind == K_RTY;

  always @(posedge clk) begin
    bus_cnt <= wb_cyc_o ? bus_cnt + 1 : 0;
    ncyc++;
  end

  always @(negedge clk) begin
    if (wb_cyc_o) begin
      if (cyc_seen && (wb_adr_o !== cap_adr || wb_dat_o !== cap_dat || wb_we_o !== cap_we || wb_sel_o !== cap_sel))
        unstable = 1;
      if (!cyc_seen) first_cyc = ncyc;
      cyc_seen = 1;
      cyc_cycles++;
      last_cyc = ncyc;
      cap_adr = wb_adr_o; cap_dat = wb_dat_o; cap_we = wb_we_o; cap_sel = wb_sel_o;
    end
    if (wb_stb_o !== wb_cyc_o) unstable = 1;
    if (tx_valid && !txv_seen) begin txv_seen = 1; first_txv = ncyc; end
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    rx_data = b; rx_valid = 1'b1;
    do begin @(negedge clk); t++; end while (!rx_ready && t < 50);
    if (!rx_ready) chk("rx_ready_wait", 32'(rx_ready), 32'd1);
    hs_cyc = ncyc;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_data = '0;
  endtask

  task automatic clear_mon();
    txq = {}; cyc_cycles = 0; cyc_seen = 0; txv_seen = 0; unstable = 0;
  endtask

  // stall: 0 = tx_ready high, 1 = random tx_ready, 2 = hold tx_ready low for 10 response cycles
  task automatic run(input bit wr, input logic [31:0] adr, input logic [31:0] dat, input logic [31:0] rd,
                     input int k, input int dly, input int stall);
    logic [7:0] exp_q[$];
    bit responded, ok;
    int t, hold, n;
    s_kind = k; s_delay = dly; rd_word = rd;
    clear_mon();
    responded = (k != K_NONE) && (dly < TMO);
    ok = responded && (k == K_ACK || k == K_ACKERR);
    exp_q = {ok ? 8'h06 : 8'h15};
    if (ok && !wr) for (int i = 3; i >= 0; i--) exp_q.push_back(rd[8*i +: 8]);
    tx_ready = stall != 2;
    send(wr ? 8'h01 : 8'h02);
    for (int i = 3; i >= 0; i--) send(adr[8*i +: 8]);
    if (wr) for (int i = 3; i >= 0; i--) send(dat[8*i +: 8]);
    t = 0; hold = 0;
    do begin
      @(posedge clk); #1;
      if (stall == 2 && txv_seen && hold < 10) begin
        chk("bp_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h06});
        hold++;
      end
      tx_ready = (stall == 2) ? (hold >= 10) : (stall == 1 ? 1'($urandom_range(0, 1)) : 1'b1);
      t++;
    end while (!(txq.size() >= exp_q.size() && !busy) && t < 400);
    tx_ready = 1'b1;
    chk("txn_done", 32'(t < 400), 32'd1);
    chk("cyc_cycles", 32'(cyc_cycles), 32'(responded ? dly + 1 : TMO));
    chk("cyc_start_lat", 32'(first_cyc - hs_cyc), 32'd1);
    chk("txv_lat", 32'(first_txv - last_cyc), 32'd1);
    chk("adr", cap_adr, adr & 32'hFFFF_FFFC);
    chk("we", 32'(cap_we), 32'(wr));
    chk("sel", 32'(cap_sel), 32'hF);
    if (wr) chk("dat_o", cap_dat, dat);
    chk("bus_stable", 32'(unstable), 32'd0);
    chk("tx_count", 32'(txq.size()), 32'(exp_q.size()));
    n = (txq.size() < exp_q.size()) ? txq.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("tx_byte%0d", i), 32'(txq[i]), 32'(exp_q[i]));
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_cyc"}, 32'(wb_cyc_o), 32'd0);
    chk({tag, "_stb"}, 32'(wb_stb_o), 32'd0);
    chk({tag, "_txv"}, 32'(tx_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rxr"}, 32'(rx_ready), 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outs("rst0");
    chk("rst0_adr", wb_adr_o, 32'd0);
    chk("rst0_dat", wb_dat_o, 32'd0);
    chk("rst0_misc", {20'd0, wb_sel_o, wb_we_o, tx_data}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_rxr", 32'(rx_ready), 32'd1);
    run(1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, K_ACK, 2, 0);
    run(0, 32'h7000_0004, 32'h0, 32'h1234_5678, K_ACK, 0, 0);
    run(0, 32'hFFFF_0000, 32'h0, 32'hAAAA_5555, K_NONE, 0, 0);
    run(1, 32'h0000_0020, 32'h0102_0304, 32'h0, K_ACKERR, 1, 0);
    run(1, 32'h0000_0024, 32'h0506_0708, 32'h0, K_RTY, 0, 0);
    run(0, 32'h0000_0028, 32'h0, 32'hCAFE_F00D, K_ERR, 3, 0);
    run(0, 32'h1234_5677, 32'h0, 32'h8765_4321, K_ACK, TMO - 1, 0);
    run(1, 32'h0000_0030, 32'h1111_2222, 32'h0, K_ACK, TMO, 0);
    run(0, 32'hABCD_0008, 32'h0, 32'h9ABC_DEF0, K_ACK, 1, 2);
    clear_mon();
    send(8'h7F);
    repeat (3) @(posedge clk);
    #1;
    chk("junk_busy", 32'(busy), 32'd0);
    chk("junk_tx", 32'(txq.size()), 32'd0);
    run(0, 32'h0000_0000, 32'h0, 32'h0BAD_F00D, K_ACK, 0, 0);
    s_kind = K_NONE;
    send(8'h02);
    for (int i = 0; i < 4; i++) send(8'h40);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_cyc", 32'(wb_cyc_o), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_bus");
    @(posedge clk); #1 reset = 1'b0;
    run(1, 32'h0000_0044, 32'h5566_7788, 32'h0, K_ACK, 0, 0);
    send(8'h01); send(8'hAA); send(8'hBB);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_addr");
    chk("rst_addr_adr", wb_adr_o, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    run(0, 32'h0000_0048, 32'h0, 32'h1357_9BDF, K_ACK, 1, 0);
    s_kind = K_ACK; s_delay = 0;
    tx_ready = 1'b0;
    send(8'h02);
    for (int i = 0; i < 4; i++) send(8'h00);
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_txv", 32'(tx_valid), 32'd1);
    #2 reset = 1'b1;
    #1 check_reset_outs("rst_resp");
    @(posedge clk); #1 reset = 1'b0; tx_ready = 1'b1;
    for (int r = 0; r < 24; r++)
      run(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
          $urandom_range(0, 4), $urandom_range(0, 20), $urandom_range(0, 1));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
